// File: rtl/ws2812_pkg.sv
// Shared decoder types: receive FSM states, pixel word size and GRB byte-lane offsets.
package ws2812_pkg;

  typedef enum logic [1:0] {
    LOW,
    HIGH,
    DRAIN
  } ws_state_t;

  localparam int BITS_PER_PIXEL = 24;

  // Byte lanes inside the assembled word, first-received byte in the top lane
  localparam int G_OFS = 16;
  localparam int R_OFS = 8;
  localparam int B_OFS = 0;

endpackage

// File: rtl/pulse_timer.sv
// Saturating run-length counter: clr starts a new run at 1, en extends it up to SAT.
// One-cycle update latency; no backpressure.
module pulse_timer #(
  parameter int W       = 4,
  parameter int SAT     = 13,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // The cycle that restarts a run is itself the first cycle of that run
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= W'(RST_VAL);
    end else if (clr) begin
      count <= W'(1);
    end else if (en && (count != W'(SAT))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ws2812_decoder.sv
// WS2812 line receiver: 2-flop sync, pulse-width bit decode, GRB assembly, latch detect; 3-cycle din-fall to pixel_valid, no backpressure.
// Optional WS2812_DEC_STATS_EN adds wrapping frame/error counters.
module ws2812_decoder
  import ws2812_pkg::*;
#(
  parameter int T_THRESH     = 6,
  parameter int MIN_HIGH     = 2,
  parameter int MAX_HIGH     = 12,
  parameter int LATCH_CYCLES = 600,
  parameter int NUM_PIXELS   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  output logic [7:0]  green_data_out,
  output logic [7:0]  red_data_out,
  output logic [7:0]  blue_data_out,
  output logic [5:0]  pixel_out,
  output logic        pixel_valid,
  output logic        frame_done,
  output logic        bit_error
`ifdef WS2812_DEC_STATS_EN
  ,
  output logic [15:0] frame_count_out,
  output logic [15:0] error_count_out
`endif
);

  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int LW = $clog2(LATCH_CYCLES + 1);
  localparam int PW = $clog2(NUM_PIXELS + 1);

  logic          din_m;
  logic          din_s;
  ws_state_t     state;
  ws_state_t     state_nx;

  logic [HW-1:0] hi_cnt;
  logic [LW-1:0] lo_cnt;
  logic          hi_clr;
  logic          hi_en;
  logic          lo_clr;
  logic          lo_en;

  logic [23:0]   shreg;
  logic [23:0]   shreg_nx;
  logic [4:0]    bit_cnt;
  logic [4:0]    bit_cnt_nx;
  logic [PW-1:0] pix_idx;
  logic [PW-1:0] pix_idx_nx;

  logic          pv_nx;
  logic          fd_nx;
  logic          be_nx;

  // hi_cnt holds the number of din_s=1 cycles of the current pulse
  pulse_timer #(
    .W       (HW),
    .SAT     (MAX_HIGH + 1),
    .RST_VAL (0)
  ) u_hi_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hi_clr),
    .en    (hi_en),
    .count (hi_cnt)
  );

  // Reset parks the low timer at saturation so reset alone never latches
  pulse_timer #(
    .W       (LW),
    .SAT     (LATCH_CYCLES),
    .RST_VAL (LATCH_CYCLES)
  ) u_lo_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (lo_clr),
    .en    (lo_en),
    .count (lo_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOW;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    hi_clr     = 1'b0;
    hi_en      = 1'b0;
    lo_clr     = 1'b0;
    lo_en      = 1'b0;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    pix_idx_nx = pix_idx;
    pv_nx      = 1'b0;
    fd_nx      = 1'b0;
    be_nx      = 1'b0;

    unique case (state)
      LOW: begin
        if (din_s) begin
          state_nx = HIGH;
          hi_clr   = 1'b1;
        end else begin
          lo_en = 1'b1;
          if (lo_cnt == LW'(LATCH_CYCLES - 1)) begin
            fd_nx      = 1'b1;
            be_nx      = (bit_cnt != '0);
            bit_cnt_nx = '0;
            pix_idx_nx = '0;
          end
        end
      end

      HIGH: begin
        if (!din_s) begin
          state_nx = LOW;
          lo_clr   = 1'b1;
          if (hi_cnt < HW'(MIN_HIGH)) begin
            be_nx      = 1'b1;
            bit_cnt_nx = '0;
          end else begin
            shreg_nx = {shreg[22:0], (hi_cnt >= HW'(T_THRESH))};
            if (bit_cnt == 5'(BITS_PER_PIXEL - 1)) begin
              bit_cnt_nx = '0;
              // Words past the last pixel belong to the downstream chain
              if (pix_idx < PW'(NUM_PIXELS)) begin
                pv_nx      = 1'b1;
                pix_idx_nx = pix_idx + 1'b1;
              end
            end else begin
              bit_cnt_nx = bit_cnt + 1'b1;
            end
          end
        end else if (hi_cnt == HW'(MAX_HIGH)) begin
          state_nx   = DRAIN;
          be_nx      = 1'b1;
          bit_cnt_nx = '0;
        end else begin
          hi_en = 1'b1;
        end
      end

      DRAIN: begin
        if (!din_s) begin
          state_nx = LOW;
          lo_clr   = 1'b1;
        end
      end

      default: begin
        state_nx = LOW;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_m          <= 1'b0;
      din_s          <= 1'b0;
      shreg          <= '0;
      bit_cnt        <= '0;
      pix_idx        <= '0;
      pixel_valid    <= 1'b0;
      frame_done     <= 1'b0;
      bit_error      <= 1'b0;
      green_data_out <= '0;
      red_data_out   <= '0;
      blue_data_out  <= '0;
      pixel_out      <= '0;
    end else begin
      din_m       <= din;
      din_s       <= din_m;
      shreg       <= shreg_nx;
      bit_cnt     <= bit_cnt_nx;
      pix_idx     <= pix_idx_nx;
      pixel_valid <= pv_nx;
      frame_done  <= fd_nx;
      bit_error   <= be_nx;
      if (pv_nx) begin
        green_data_out <= shreg_nx[G_OFS +: 8];
        red_data_out   <= shreg_nx[R_OFS +: 8];
        blue_data_out  <= shreg_nx[B_OFS +: 8];
        pixel_out      <= 6'(pix_idx);
      end
    end
  end

`ifdef WS2812_DEC_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_count_out <= '0;
      error_count_out <= '0;
    end else begin
      if (fd_nx) frame_count_out <= frame_count_out + 1'b1;
      if (be_nx) error_count_out <= error_count_out + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ws2812_decoder.sv
// Randomized bench for ws2812_decoder: pulse-level reference model vs. observed strobes.
module tb_ws2812_decoder;

  localparam int T_THRESH = 6;
  localparam int MIN_HIGH = 2;
  localparam int MAX_HIGH = 12;
  localparam int LATCH    = 600;
  localparam int NPIX     = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic [7:0] g;
  logic [7:0] r;
  logic [7:0] b;
  logic [5:0] pix;
  logic       pv;
  logic       fd;
  logic       be;
`ifdef WS2812_DEC_STATS_EN
  logic [15:0] fcnt;
  logic [15:0] ecnt;
`endif

  ws2812_decoder #(
    .T_THRESH     (T_THRESH),
    .MIN_HIGH     (MIN_HIGH),
    .MAX_HIGH     (MAX_HIGH),
    .LATCH_CYCLES (LATCH),
    .NUM_PIXELS   (NPIX)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .din            (din),
    .green_data_out (g),
    .red_data_out   (r),
    .blue_data_out  (b),
    .pixel_out      (pix),
    .pixel_valid    (pv),
    .frame_done     (fd),
    .bit_error      (be)
`ifdef WS2812_DEC_STATS_EN
    ,
    .frame_count_out (fcnt),
    .error_count_out (ecnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef logic [29:0] pix_t;
  pix_t obs_pix[$];
  pix_t exp_pix[$];
  int obs_fd, obs_be, obs_both, obs_excl;
  int last_pv_cyc, last_fd_cyc, last_fall_cyc;
  int exp_fd, exp_be, exp_both;
  logic [23:0] m_word;
  int m_nbits, m_idx;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pv) begin
        obs_pix.push_back({pix, g, r, b});
        last_pv_cyc = cyc;
      end
      if (fd) begin
        obs_fd++;
        last_fd_cyc = cyc;
      end
      if (be) obs_be++;
      if (fd && be) obs_both++;
      if (pv && be) obs_excl++;
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    din   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs_pix.delete();
    exp_pix.delete();
    obs_fd = 0; obs_be = 0; obs_both = 0; obs_excl = 0;
    exp_fd = 0; exp_be = 0; exp_both = 0;
    m_word = '0; m_nbits = 0; m_idx = 0;
    rst_n = 1'b1;
  endtask

  // One high pulse of hi cycles followed by lo low cycles, then the model's view of it
  task automatic send_pulse(input int hi, input int lo);
    din = 1'b1;
    repeat (hi) @(posedge clk);
    #1;
    din = 1'b0;
    last_fall_cyc = cyc;
    repeat (lo) @(posedge clk);
    #1;
    if (hi < MIN_HIGH || hi > MAX_HIGH) begin
      exp_be++;
      m_nbits = 0;
    end else begin
      m_word = {m_word[22:0], (hi >= T_THRESH)};
      m_nbits++;
      if (m_nbits == 24) begin
        m_nbits = 0;
        if (m_idx < NPIX) begin
          exp_pix.push_back({6'(m_idx), m_word});
          m_idx++;
        end
      end
    end
    if (lo >= LATCH) begin
      exp_fd++;
      if (m_nbits != 0) begin
        exp_be++;
        exp_both++;
      end
      m_nbits = 0;
      m_idx = 0;
    end
  endtask

  function automatic int rnd_hi(input logic bv);
    return bv ? int'($urandom_range(T_THRESH, MAX_HIGH)) : int'($urandom_range(MIN_HIGH, T_THRESH - 1));
  endfunction

  task automatic send_word(input logic [23:0] data, input int lo_last);
    for (int i = 23; i >= 0; i--) begin
      send_pulse(rnd_hi(data[i]), (i == 0) ? lo_last : int'($urandom_range(2, 8)));
    end
  endtask

  task automatic send_bits(input int n, input int lo_last);
    for (int i = 0; i < n; i++) begin
      send_pulse(rnd_hi(1'($urandom)), (i == n - 1) ? lo_last : int'($urandom_range(2, 8)));
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({g, r, b, pix, pv, fd, be} !== 33'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {g, r, b, pix, pv, fd, be});
    end
`ifdef WS2812_DEC_STATS_EN
    checks++;
    if ({fcnt, ecnt} !== 32'd0) begin
      errors++;
      $display("FAIL reset_stats: got %h expected 0", {fcnt, ecnt});
    end
`endif
    repeat (LATCH + 20) @(posedge clk);
    #1;
    checks++;
    if (obs_fd !== 0) begin
      errors++;
      $display("FAIL reset_no_frame_done: got %0d expected 0", obs_fd);
    end
    checks++;
    if (obs_be !== 0) begin
      errors++;
      $display("FAIL reset_no_bit_error: got %0d expected 0", obs_be);
    end
  endtask

  task automatic test_single_pixel();
    logic [23:0] d;
    pix_t p;
    apply_reset();
    d = 24'hFF0000;
    for (int i = 23; i >= 0; i--) send_pulse(d[i] ? 8 : 4, 7);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (obs_pix.size() !== 1) begin
      errors++;
      $display("FAIL single_count: got %0d expected 1", obs_pix.size());
    end
    p = (obs_pix.size() > 0) ? obs_pix[0] : '1;
    checks++;
    if (p !== {6'd0, 24'hFF0000}) begin
      errors++;
      $display("FAIL single_data: got %h expected %h", p, {6'd0, 24'hFF0000});
    end
    checks++;
    if ((last_pv_cyc - last_fall_cyc) !== 3) begin
      errors++;
      $display("FAIL single_latency: got %0d expected 3", last_pv_cyc - last_fall_cyc);
    end
    checks++;
    if (obs_be !== 0) begin
      errors++;
      $display("FAIL single_bit_error: got %0d expected 0", obs_be);
    end
  endtask

  task automatic test_frame();
    pix_t p;
    int fall;
    apply_reset();
    send_word(24'h0000FF, 5);
    send_word(24'h00FF00, 3);
    send_word(24'h123456, LATCH + 10);
    fall = last_fall_cyc;
    checks++;
    if ((last_fd_cyc - fall) !== LATCH + 2) begin
      errors++;
      $display("FAIL frame_latch_latency: got %0d expected %0d", last_fd_cyc - fall, LATCH + 2);
    end
    send_word(24'($urandom), 10);
    checks++;
    if (obs_pix.size() !== exp_pix.size()) begin
      errors++;
      $display("FAIL frame_count: got %0d expected %0d", obs_pix.size(), exp_pix.size());
    end
    for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
      checks++;
      if (obs_pix[i] !== exp_pix[i]) begin
        errors++;
        $display("FAIL frame_pix[%0d]: got %h expected %h", i, obs_pix[i], exp_pix[i]);
      end
    end
    p = (obs_pix.size() > 2) ? obs_pix[2] : '1;
    checks++;
    if (p !== {6'd2, 24'h123456}) begin
      errors++;
      $display("FAIL frame_third: got %h expected %h", p, {6'd2, 24'h123456});
    end
    checks++;
    if (obs_fd !== 1) begin
      errors++;
      $display("FAIL frame_done_count: got %0d expected 1", obs_fd);
    end
  endtask

  task automatic test_latch_boundary();
    apply_reset();
    send_word(24'($urandom), LATCH - 1);
    send_word(24'($urandom), LATCH);
    send_word(24'($urandom), 8);
    checks++;
    if (obs_pix.size() !== exp_pix.size()) begin
      errors++;
      $display("FAIL boundary_count: got %0d expected %0d", obs_pix.size(), exp_pix.size());
    end
    for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
      checks++;
      if (obs_pix[i] !== exp_pix[i]) begin
        errors++;
        $display("FAIL boundary_pix[%0d]: got %h expected %h", i, obs_pix[i], exp_pix[i]);
      end
    end
    checks++;
    if (obs_fd !== exp_fd) begin
      errors++;
      $display("FAIL boundary_frame_done: got %0d expected %0d", obs_fd, exp_fd);
    end
  endtask

  task automatic test_partial();
    apply_reset();
    send_bits(12, LATCH);
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (obs_pix.size() !== 0) begin
      errors++;
      $display("FAIL partial_no_pixel: got %0d expected 0", obs_pix.size());
    end
    checks++;
    if (obs_fd !== exp_fd) begin
      errors++;
      $display("FAIL partial_frame_done: got %0d expected %0d", obs_fd, exp_fd);
    end
    checks++;
    if (obs_both !== exp_both) begin
      errors++;
      $display("FAIL partial_coincident: got %0d expected %0d", obs_both, exp_both);
    end
    checks++;
    if (obs_be !== exp_be) begin
      errors++;
      $display("FAIL partial_bit_error: got %0d expected %0d", obs_be, exp_be);
    end
  endtask

  task automatic test_errors();
    apply_reset();
    send_bits(5, 4);
    send_pulse(1, 5);
    send_bits(7, 4);
    send_pulse(MAX_HIGH + 1, 6);
    send_word(24'($urandom), 8);
    checks++;
    if (obs_be !== exp_be) begin
      errors++;
      $display("FAIL errors_count: got %0d expected %0d", obs_be, exp_be);
    end
    checks++;
    if (obs_pix.size() !== exp_pix.size()) begin
      errors++;
      $display("FAIL errors_pix_count: got %0d expected %0d", obs_pix.size(), exp_pix.size());
    end
    for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
      checks++;
      if (obs_pix[i] !== exp_pix[i]) begin
        errors++;
        $display("FAIL errors_pix[%0d]: got %h expected %h", i, obs_pix[i], exp_pix[i]);
      end
    end
  endtask

  task automatic test_widths();
    int tbl [4];
    pix_t p;
    tbl = '{MIN_HIGH, T_THRESH - 1, T_THRESH, MAX_HIGH};
    apply_reset();
    for (int i = 0; i < 24; i++) send_pulse(tbl[i % 4], (i == 23) ? 8 : 3);
    p = (obs_pix.size() > 0) ? obs_pix[0] : '1;
    checks++;
    if (p !== {6'd0, 24'h333333}) begin
      errors++;
      $display("FAIL widths_data: got %h expected %h", p, {6'd0, 24'h333333});
    end
    checks++;
    if (obs_be !== 0) begin
      errors++;
      $display("FAIL widths_bit_error: got %0d expected 0", obs_be);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] d;
    apply_reset();
    for (int w = 0; w < 6; w++) begin
      d = 24'($urandom);
      for (int i = 23; i >= 0; i--) send_pulse(rnd_hi(d[i]), (w == 5 && i == 0) ? 8 : 1);
    end
    checks++;
    if (obs_pix.size() !== exp_pix.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected %0d", obs_pix.size(), exp_pix.size());
    end
    for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
      checks++;
      if (obs_pix[i] !== exp_pix[i]) begin
        errors++;
        $display("FAIL b2b_pix[%0d]: got %h expected %h", i, obs_pix[i], exp_pix[i]);
      end
    end
    checks++;
    if (obs_be !== 0) begin
      errors++;
      $display("FAIL b2b_bit_error: got %0d expected 0", obs_be);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int p = 0; p < NPIX + 1; p++) send_word(24'($urandom), (p == NPIX) ? LATCH : 3);
    checks++;
    if (obs_pix.size() !== NPIX) begin
      errors++;
      $display("FAIL sat_count: got %0d expected %0d", obs_pix.size(), NPIX);
    end
    send_word(24'($urandom), 8);
    checks++;
    if (obs_pix.size() !== exp_pix.size()) begin
      errors++;
      $display("FAIL sat_total: got %0d expected %0d", obs_pix.size(), exp_pix.size());
    end
    for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
      checks++;
      if (obs_pix[i] !== exp_pix[i]) begin
        errors++;
        $display("FAIL sat_pix[%0d]: got %h expected %h", i, obs_pix[i], exp_pix[i]);
      end
    end
    checks++;
    if (obs_be !== 0 || obs_excl !== 0) begin
      errors++;
      $display("FAIL sat_errors: got be=%0d excl=%0d expected 0", obs_be, obs_excl);
    end
  endtask

`ifdef WS2812_DEC_STATS_EN
  task automatic test_stats();
    apply_reset();
    send_word(24'($urandom), LATCH);
    send_word(24'($urandom), LATCH);
    send_pulse(1, 10);
    checks++;
    if (fcnt !== 16'(exp_fd)) begin
      errors++;
      $display("FAIL stats_frames: got %0d expected %0d", fcnt, exp_fd);
    end
    checks++;
    if (ecnt !== 16'(exp_be)) begin
      errors++;
      $display("FAIL stats_errors: got %0d expected %0d", ecnt, exp_be);
    end
  endtask
`endif

  task automatic test_reset_mid_word();
    apply_reset();
    send_word(24'($urandom) | 24'h800001, 5);
    send_bits(10, 3);
    din = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({g, r, b, pix, pv, fd, be} !== 33'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h expected 0", {g, r, b, pix, pv, fd, be});
    end
`ifdef WS2812_DEC_STATS_EN
    checks++;
    if ({fcnt, ecnt} !== 32'd0) begin
      errors++;
      $display("FAIL midreset_stats: got %h expected 0", {fcnt, ecnt});
    end
`endif
    apply_reset();
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if ((obs_fd + obs_be + obs_pix.size()) !== 0) begin
      errors++;
      $display("FAIL midreset_quiet: got %0d strobes expected 0", obs_fd + obs_be + obs_pix.size());
    end
    send_word(24'($urandom), 8);
    checks++;
    if (obs_pix.size() !== 1 || exp_pix.size() !== 1 || obs_pix[0] !== exp_pix[0]) begin
      errors++;
      $display("FAIL midreset_next_pixel: got %0d pixels expected 1 matching model", obs_pix.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_frame();
    test_latch_boundary();
    test_partial();
    test_errors();
    test_widths();
    test_back_to_back();
    test_saturation();
`ifdef WS2812_DEC_STATS_EN
    test_stats();
`endif
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
